// File: rtl/jk_ctrl_pkg.sv
// Shared definitions for the JK counter controller: opcode encodings and FSM states.
package jk_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_HOLD = 2'd0,
    OP_LOAD = 2'd1,
    OP_UP   = 2'd2,
    OP_DOWN = 2'd3
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/jk_count_ctrl_if.sv
// Command bus and status signals of the JK counter controller.
// Handshake: a command transfers on a clk edge where cmd_valid && cmd_ready; the
// requester keeps cmd_valid/op/data/count stable until then, and may drop or change them afterwards.
interface jk_count_ctrl_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [WIDTH-1:0] cmd_data;
  logic [CNT_W-1:0] cmd_count;
  logic [WIDTH-1:0] q;
  logic             busy;
  logic             done;

  modport master (
    output cmd_valid, cmd_op, cmd_data, cmd_count,
    input  cmd_ready, q, busy, done
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_data, cmd_count,
    output cmd_ready, q, busy, done
  );
endinterface

// File: rtl/jk_cell.sv
// Posedge JK flip-flop without reset: 00 hold, 01 clear, 10 set, 11 toggle.
module jk_cell (
  input  logic clk,
  input  logic j,
  input  logic k,
  output logic q
);
  always_ff @(posedge clk) begin
    case ({j, k})
      2'b01:   q <= 1'b0;
      2'b10:   q <= 1'b1;
      2'b11:   q <= ~q;
      default: q <= q;
    endcase
  end
endmodule

// File: rtl/jk_count_ctrl.sv
// Command-driven controller steering a bank of JK cells: load, count up/down, or timed hold.
module jk_count_ctrl
  import jk_ctrl_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  jk_count_ctrl_if.slave    bus,
  output state_t            state_dbg
);

  state_t           state;
  op_t              op_r;
  logic [WIDTH-1:0] data_r;
  logic [CNT_W-1:0] remaining;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] j;
  logic [WIDTH-1:0] k;
  logic [WIDTH-1:0] mask;
  logic             carry;

  // A bit toggles when every lower bit is 1 (counting up) or 0 (counting down).
  always_comb begin
    mask  = '0;
    carry = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      mask[i] = carry;
      carry   = carry & ((op_r == OP_UP) ? q[i] : ~q[i]);
    end
    if (op_r == OP_HOLD) mask = '0;
  end

  // Reset clears the bank through the k inputs, since the cells carry no reset of their own.
  always_comb begin
    j = '0;
    k = '0;
    if (rst) begin
      k = '1;
    end else begin
      case (state)
        ST_LOAD: begin
          j = data_r;
          k = ~data_r;
        end
        ST_RUN: begin
          j = mask;
          k = mask;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      op_r      <= OP_HOLD;
      data_r    <= '0;
      remaining <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.cmd_valid) begin
            op_r <= op_t'(bus.cmd_op);
            if (op_t'(bus.cmd_op) == OP_LOAD) begin
              data_r <= bus.cmd_data;
              state  <= ST_LOAD;
            end else begin
              remaining <= bus.cmd_count;
              state     <= (bus.cmd_count == '0) ? ST_DONE : ST_RUN;
            end
          end
        end
        ST_LOAD: state <= ST_DONE;
        ST_RUN: begin
          remaining <= remaining - CNT_W'(1);
          if (remaining == CNT_W'(1)) state <= ST_DONE;
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    jk_cell u_cell (
      .clk (clk),
      .j   (j[i]),
      .k   (k[i]),
      .q   (q[i])
    );
  end

  assign bus.cmd_ready = (state == ST_IDLE) && !rst;
  assign bus.busy      = (state != ST_IDLE);
  assign bus.done      = (state == ST_DONE);
  assign bus.q         = q;
  assign state_dbg     = state;

endmodule

// File: tb/tb_jk_count_ctrl.sv
// Bench for jk_count_ctrl: directed scenarios plus random commands against an arithmetic model.
module tb_jk_count_ctrl;
  import jk_ctrl_pkg::*;

  localparam int W = 4;
  localparam int C = 8;

  logic   clk = 1'b0;
  logic   rst;
  state_t state_dbg;
  int     checks   = 0;
  int     failures = 0;
  logic [W-1:0] exp_q;

  jk_count_ctrl_if #(.WIDTH(W), .CNT_W(C)) bus ();

  jk_count_ctrl #(.WIDTH(W), .CNT_W(C)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic scramble();
    bus.cmd_op    = 2'($urandom_range(0, 3));
    bus.cmd_data  = W'($urandom);
    bus.cmd_count = C'($urandom);
  endtask

  function automatic logic [W-1:0] model_step(input logic [1:0] op, input logic [W-1:0] v);
    if (op == OP_UP)   return v + W'(1);
    if (op == OP_DOWN) return v - W'(1);
    return v;
  endfunction

  task automatic do_cmd(input logic [1:0] op, input logic [W-1:0] data, input logic [C-1:0] cnt);
    chk("ready_before", 32'(bus.cmd_ready), 32'd1);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_data  = data;
    bus.cmd_count = cnt;
    tick();
    bus.cmd_valid = 1'b0;
    scramble();
    if (op == OP_LOAD) begin
      chk("load_busy", 32'(bus.busy), 32'd1);
      chk("load_nodone", 32'(bus.done), 32'd0);
      chk("load_notready", 32'(bus.cmd_ready), 32'd0);
      tick();
      exp_q = data;
      chk("load_q", 32'(bus.q), 32'(exp_q));
      chk("load_done", 32'(bus.done), 32'd1);
    end else if (cnt == '0) begin
      chk("zero_done", 32'(bus.done), 32'd1);
      chk("zero_busy", 32'(bus.busy), 32'd1);
      chk("zero_q", 32'(bus.q), 32'(exp_q));
    end else begin
      chk("run_busy", 32'(bus.busy), 32'd1);
      chk("run_q0", 32'(bus.q), 32'(exp_q));
      for (int n = 0; n < int'(cnt); n++) begin
        chk("run_nodone", 32'(bus.done), 32'd0);
        scramble();
        tick();
        exp_q = model_step(op, exp_q);
        chk("run_q", 32'(bus.q), 32'(exp_q));
      end
      chk("run_done", 32'(bus.done), 32'd1);
      chk("run_busy_done", 32'(bus.busy), 32'd1);
    end
    tick();
    chk("end_nodone", 32'(bus.done), 32'd0);
    chk("end_idle_busy", 32'(bus.busy), 32'd0);
    chk("end_ready", 32'(bus.cmd_ready), 32'd1);
    chk("end_q", 32'(bus.q), 32'(exp_q));
  endtask

  initial begin
    rst           = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = OP_HOLD;
    bus.cmd_data  = '0;
    bus.cmd_count = '0;
    exp_q         = '0;

    // Reset
    tick();
    tick();
    chk("rst_ready", 32'(bus.cmd_ready), 32'd0);
    chk("rst_q", 32'(bus.q), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_state", 32'(state_dbg), 32'(ST_IDLE));
    rst = 1'b0;
    #1;
    chk("post_rst_ready", 32'(bus.cmd_ready), 32'd1);

    // Directed scenarios
    do_cmd(OP_LOAD, 4'hA, 8'd0);
    do_cmd(OP_LOAD, 4'hE, 8'd9);
    do_cmd(OP_UP,   4'h0, 8'd3);
    chk("up_wrap_q", 32'(bus.q), 32'h1);
    do_cmd(OP_LOAD, 4'h1, 8'd0);
    do_cmd(OP_DOWN, 4'h0, 8'd2);
    chk("down_wrap_q", 32'(bus.q), 32'hF);
    do_cmd(OP_UP,   4'h5, 8'd0);
    do_cmd(OP_HOLD, 4'h5, 8'd4);

    // New command held valid during RUN is taken once, after the current one ends
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = OP_UP;
    bus.cmd_count = 8'd4;
    tick();
    bus.cmd_op    = OP_LOAD;
    bus.cmd_data  = 4'h3;
    bus.cmd_count = 8'd7;
    for (int n = 0; n < 4; n++) begin
      chk("hv_notready", 32'(bus.cmd_ready), 32'd0);
      tick();
      exp_q = exp_q + W'(1);
      chk("hv_q", 32'(bus.q), 32'(exp_q));
    end
    chk("hv_done", 32'(bus.done), 32'd1);
    tick();
    chk("hv_ready", 32'(bus.cmd_ready), 32'd1);
    tick();
    bus.cmd_valid = 1'b0;
    chk("hv_load_busy", 32'(bus.busy), 32'd1);
    tick();
    exp_q = 4'h3;
    chk("hv_load_q", 32'(bus.q), 32'(exp_q));
    chk("hv_load_done", 32'(bus.done), 32'd1);
    for (int n = 0; n < 3; n++) begin
      tick();
      chk("hv_once_busy", 32'(bus.busy), 32'd0);
      chk("hv_once_q", 32'(bus.q), 32'(exp_q));
    end

    // Reset in the middle of a long UP run
    do_cmd(OP_LOAD, 4'h0, 8'd0);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = OP_UP;
    bus.cmd_count = 8'd200;
    tick();
    bus.cmd_valid = 1'b0;
    for (int n = 0; n < 49; n++) begin
      tick();
      exp_q = exp_q + W'(1);
    end
    chk("abort_pre_q", 32'(bus.q), 32'(exp_q));
    rst = 1'b1;
    tick();
    exp_q = '0;
    chk("abort_q", 32'(bus.q), 32'd0);
    chk("abort_done", 32'(bus.done), 32'd0);
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_ready_in_rst", 32'(bus.cmd_ready), 32'd0);
    rst = 1'b0;
    #1;
    chk("abort_ready", 32'(bus.cmd_ready), 32'd1);
    for (int n = 0; n < 3; n++) begin
      tick();
      chk("abort_nodone", 32'(bus.done), 32'd0);
      chk("abort_hold_q", 32'(bus.q), 32'd0);
    end

    // Random commands
    repeat (30) begin
      int gap;
      gap = $urandom_range(0, 2);
      for (int n = 0; n < gap; n++) begin
        tick();
        chk("gap_q", 32'(bus.q), 32'(exp_q));
      end
      do_cmd(2'($urandom_range(0, 3)), W'($urandom), C'($urandom_range(0, 9)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
